id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 145 ++++++++++++++
 tb/tb_id_ex_stage.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall bubbles and
// optional EX/MEM and MEM/WB operand forwarding (enabled by defining ID_EX_FORWARD_EN).
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_reg_write,
  input  logic        in_mem_read,
  input  logic        in_alusrc_b,
  input  logic        in_sign,
  input  logic [4:0]  in_rs_addr,
  input  logic [4:0]  in_rt_addr,
  input  logic [4:0]  in_wr_addr,
  input  logic [31:0] in_rs_data,
  input  logic [31:0] in_rt_data,
  input  logic [31:0] in_imm,
  input  logic [5:0]  in_alufun,
  input  logic        flush,
  input  logic        exmem_reg_write,
  input  logic        memwb_reg_write,
  input  logic [4:0]  exmem_wr_addr,
  input  logic [4:0]  memwb_wr_addr,
  input  logic [31:0] exmem_result,
  input  logic [31:0] memwb_result,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [5:0]  ALUFun,
  output logic        Sign,
  output logic        out_valid,
  output logic        out_reg_write,
  output logic        out_mem_read,
  output logic [4:0]  out_wr_addr,
  output logic [31:0] out_rt_fwd,
  output logic        stall
);

  logic        valid_q, valid_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_read_q, mem_read_d;
  logic        alusrc_b_q;
  logic        sign_q;
  logic [4:0]  rs_addr_q, rt_addr_q, wr_addr_q;
  logic [31:0] rs_data_q, rt_data_q, imm_q;
  logic [5:0]  alufun_q;

  logic        hazard;
  logic        bubble;
  logic [31:0] rsFwd, rtFwd;

  // A load in EX whose destination feeds the incoming instruction cannot be forwarded in time.
  assign hazard = valid_q & mem_read_q & (wr_addr_q != 5'd0) & in_valid &
                  ((in_rs_addr == wr_addr_q) | ((in_rt_addr == wr_addr_q) & ~in_alusrc_b));
  assign stall  = hazard & ~flush;
  assign bubble = flush | stall;

  always_comb begin
    valid_d     = in_valid;
    reg_write_d = in_reg_write;
    mem_read_d  = in_mem_read;
    if (bubble) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      alusrc_b_q  <= 1'b0;
      sign_q      <= 1'b0;
      rs_addr_q   <= 5'd0;
      rt_addr_q   <= 5'd0;
      wr_addr_q   <= 5'd0;
      rs_data_q   <= 32'd0;
      rt_data_q   <= 32'd0;
      imm_q       <= 32'd0;
      alufun_q    <= 6'd0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      alusrc_b_q  <= in_alusrc_b;
      sign_q      <= in_sign;
      rs_addr_q   <= in_rs_addr;
      rt_addr_q   <= in_rt_addr;
      wr_addr_q   <= in_wr_addr;
      rs_data_q   <= in_rs_data;
      rt_data_q   <= in_rt_data;
      imm_q       <= in_imm;
      alufun_q    <= in_alufun;
    end
  end

`ifdef ID_EX_FORWARD_EN
  // EX/MEM is the younger producer, so it takes priority over MEM/WB; $0 is never forwarded.
  function automatic logic [31:0] fwdSel(
    input logic [4:0]  srcAddr,
    input logic [31:0] regData,
    input logic        exRw,
    input logic [4:0]  exWr,
    input logic [31:0] exRes,
    input logic        wbRw,
    input logic [4:0]  wbWr,
    input logic [31:0] wbRes
  );
    logic [31:0] sel;
    sel = regData;
    if (exRw && (exWr != 5'd0) && (exWr == srcAddr))
      sel = exRes;
    else if (wbRw && (wbWr != 5'd0) && (wbWr == srcAddr))
      sel = wbRes;
    return sel;
  endfunction

  always_comb begin
    rsFwd = fwdSel(rs_addr_q, rs_data_q, exmem_reg_write, exmem_wr_addr, exmem_result,
                   memwb_reg_write, memwb_wr_addr, memwb_result);
    rtFwd = fwdSel(rt_addr_q, rt_data_q, exmem_reg_write, exmem_wr_addr, exmem_result,
                   memwb_reg_write, memwb_wr_addr, memwb_result);
  end
`else
  logic unusedFwd;
  assign unusedFwd = ^{exmem_reg_write, memwb_reg_write, exmem_wr_addr, memwb_wr_addr,
                       exmem_result, memwb_result, rs_addr_q, rt_addr_q};

  always_comb begin
    rsFwd = rs_data_q;
    rtFwd = rt_data_q;
  end
`endif

  assign A             = rsFwd;
  assign B             = alusrc_b_q ? imm_q : rtFwd;
  assign out_rt_fwd    = rtFwd;
  assign ALUFun        = alufun_q;
  assign Sign          = sign_q;
  assign out_valid     = valid_q;
  assign out_reg_write = reg_write_q;
  assign out_mem_read  = mem_read_q;
  assign out_wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus queues expected values, a negedge monitor compares.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_reg_write, in_mem_read, in_alusrc_b, in_sign;
  logic [4:0]  in_rs_addr, in_rt_addr, in_wr_addr;
  logic [31:0] in_rs_data, in_rt_data, in_imm;
  logic [5:0]  in_alufun;
  logic        flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_wr_addr, memwb_wr_addr;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] A, B, out_rt_fwd;
  logic [5:0]  ALUFun;
  logic        Sign, out_valid, out_reg_write, out_mem_read, stall;
  logic [4:0]  out_wr_addr;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_alusrc_b(in_alusrc_b), .in_sign(in_sign),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_wr_addr(in_wr_addr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_alufun(in_alufun), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
    .exmem_wr_addr(exmem_wr_addr), .memwb_wr_addr(memwb_wr_addr),
    .exmem_result(exmem_result), .memwb_result(memwb_result),
    .A(A), .B(B), .ALUFun(ALUFun), .Sign(Sign),
    .out_valid(out_valid), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_wr_addr(out_wr_addr), .out_rt_fwd(out_rt_fwd), .stall(stall)
  );

  typedef enum int {S_A, S_B, S_ALUFUN, S_SIGN, S_VALID, S_RW, S_MR, S_WR, S_RTF, S_STALL} sigId_t;
  typedef struct {
    string       name;
    sigId_t      id;
    logic [31:0] exp;
  } expect_t;

  expect_t     sbQ[$];
  expect_t     monE;
  logic [31:0] monAct;
  int          total = 0;
  int          bad = 0;

  function automatic logic [31:0] sample(input sigId_t id);
    case (id)
      S_A:      return A;
      S_B:      return B;
      S_ALUFUN: return {26'd0, ALUFun};
      S_SIGN:   return {31'd0, Sign};
      S_VALID:  return {31'd0, out_valid};
      S_RW:     return {31'd0, out_reg_write};
      S_MR:     return {31'd0, out_mem_read};
      S_WR:     return {27'd0, out_wr_addr};
      S_RTF:    return out_rt_fwd;
      default:  return {31'd0, stall};
    endcase
  endfunction

  // Monitor: the DUT presents a stage result every cycle, checked mid-cycle.
  always @(negedge clk) begin
    while (sbQ.size() > 0) begin
      monE   = sbQ.pop_front();
      monAct = sample(monE.id);
      total++;
      if (monAct !== monE.exp) begin
        bad++;
        $display("[TB] FAIL %s: got %h want %h", monE.name, monAct, monE.exp);
      end
    end
  end

  task automatic expectSig(input string name, input sigId_t id, input logic [31:0] value);
    expect_t e;
    e.name = name;
    e.id   = id;
    e.exp  = value;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic v, input logic rw, input logic mr, input logic asb,
                               input logic sg, input logic [4:0] rsA, input logic [4:0] rtA,
                               input logic [4:0] wrA, input logic [31:0] rsD,
                               input logic [31:0] rtD, input logic [31:0] imm,
                               input logic [5:0] fun);
    in_valid = v; in_reg_write = rw; in_mem_read = mr; in_alusrc_b = asb; in_sign = sg;
    in_rs_addr = rsA; in_rt_addr = rtA; in_wr_addr = wrA;
    in_rs_data = rsD; in_rt_data = rtD; in_imm = imm; in_alufun = fun;
  endtask

  task automatic setFwd(input logic exRw, input logic [4:0] exWr, input logic [31:0] exRes,
                        input logic wbRw, input logic [4:0] wbWr, input logic [31:0] wbRes);
    exmem_reg_write = exRw; exmem_wr_addr = exWr; exmem_result = exRes;
    memwb_reg_write = wbRw; memwb_wr_addr = wbWr; memwb_result = wbRes;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 6'd0);
    setFwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    expectSig("rst0_valid", S_VALID, 32'd0);
    expectSig("rst0_stall", S_STALL, 32'd0);
    checkOutput();

    // Load a real instruction, then reset with in_valid=1 and a pending hazard.
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 5'd4, 5'd3,
                  32'h123, 32'h456, 32'h789, 6'h2A);
    tick();
    expectSig("pre_A", S_A, 32'h123);
    expectSig("pre_fun", S_ALUFUN, 32'h2A);
    expectSig("pre_sign", S_SIGN, 32'd1);
    expectSig("pre_stall", S_STALL, 32'd1);
    checkOutput();
    reset = 1'b0;
    tick();
    expectSig("rst_valid", S_VALID, 32'd0);
    expectSig("rst_A", S_A, 32'd0);
    expectSig("rst_B", S_B, 32'd0);
    expectSig("rst_fun", S_ALUFUN, 32'd0);
    expectSig("rst_sign", S_SIGN, 32'd0);
    expectSig("rst_wr", S_WR, 32'd0);
    expectSig("rst_rw", S_RW, 32'd0);
    expectSig("rst_mr", S_MR, 32'd0);
    expectSig("rst_stall", S_STALL, 32'd0);
    checkOutput();
    reset = 1'b1;

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3,
                  32'h0000001D, 32'h80000001, 32'h44, 6'b000000);
    tick();
    expectSig("pass_A", S_A, 32'h0000001D);
    expectSig("pass_B", S_B, 32'h80000001);
    expectSig("pass_fun", S_ALUFUN, 32'd0);
    expectSig("pass_rtf", S_RTF, 32'h80000001);
    expectSig("pass_valid", S_VALID, 32'd1);
    expectSig("pass_rw", S_RW, 32'd1);
    expectSig("pass_wr", S_WR, 32'd3);
    expectSig("pass_stall", S_STALL, 32'd0);
    checkOutput();

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 5'd7, 5'd0,
                  32'h10, 32'h7, 32'hFFFFFFF0, 6'h21);
    tick();
    expectSig("imm_A", S_A, 32'h10);
    expectSig("imm_B", S_B, 32'hFFFFFFF0);
    expectSig("imm_rtf", S_RTF, 32'h7);
    expectSig("imm_fun", S_ALUFUN, 32'h21);
    expectSig("imm_sign", S_SIGN, 32'd1);
    expectSig("imm_rw", S_RW, 32'd0);
    checkOutput();

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 5'd6, 5'd9,
                  32'h12345678, 32'h0BADF00D, 32'd0, 6'h20);
    tick();
    setFwd(1'b1, 5'd5, 32'hAAAA0000, 1'b1, 5'd5, 32'h55550000);
    #1;
    expectSig("fwd_both_A", S_A, FWD ? 32'hAAAA0000 : 32'h12345678);
    expectSig("fwd_both_rtf", S_RTF, 32'h0BADF00D);
    checkOutput();
    setFwd(1'b0, 5'd5, 32'hAAAA0000, 1'b1, 5'd5, 32'h55550000);
    #1;
    expectSig("fwd_wb_A", S_A, FWD ? 32'h55550000 : 32'h12345678);
    checkOutput();
    setFwd(1'b0, 5'd5, 32'hAAAA0000, 1'b1, 5'd6, 32'h66660000);
    #1;
    expectSig("fwd_rt_A", S_A, 32'h12345678);
    expectSig("fwd_rt_rtf", S_RTF, FWD ? 32'h66660000 : 32'h0BADF00D);
    expectSig("fwd_rt_B", S_B, FWD ? 32'h66660000 : 32'h0BADF00D);
    checkOutput();
    setFwd(1'b1, 5'd6, 32'h77770000, 1'b1, 5'd7, 32'h88880000);
    #1;
    expectSig("fwd_ex_rtf", S_RTF, FWD ? 32'h77770000 : 32'h0BADF00D);
    expectSig("fwd_miss_A", S_A, 32'h12345678);
    checkOutput();

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9,
                  32'd0, 32'd0, 32'd0, 6'd0);
    setFwd(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF);
    tick();
    expectSig("r0_A", S_A, 32'd0);
    expectSig("r0_B", S_B, 32'd0);
    expectSig("r0_rtf", S_RTF, 32'd0);
    checkOutput();
    setFwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Load-use on rs: one bubble, then the held instruction enters.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd8,
                  32'h100, 32'h200, 32'd0, 6'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 5'd3, 5'd10,
                  32'h300, 32'h400, 32'd0, 6'h22);
    #1;
    expectSig("lu_stall", S_STALL, 32'd1);
    expectSig("lu_ld_mr", S_MR, 32'd1);
    expectSig("lu_ld_wr", S_WR, 32'd8);
    checkOutput();
    tick();
    expectSig("lu_bub_valid", S_VALID, 32'd0);
    expectSig("lu_bub_rw", S_RW, 32'd0);
    expectSig("lu_bub_mr", S_MR, 32'd0);
    expectSig("lu_bub_stall", S_STALL, 32'd0);
    checkOutput();
    tick();
    expectSig("lu_go_valid", S_VALID, 32'd1);
    expectSig("lu_go_wr", S_WR, 32'd10);
    expectSig("lu_go_A", S_A, 32'h300);
    expectSig("lu_go_fun", S_ALUFUN, 32'h22);
    checkOutput();

    // rt only matters when B really comes from rt.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd8,
                  32'h1, 32'h2, 32'd0, 6'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd8, 5'd11,
                  32'h5, 32'h6, 32'h9, 6'd0);
    #1;
    expectSig("rt_imm_stall", S_STALL, 32'd0);
    checkOutput();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd8,
                  32'h1, 32'h2, 32'd0, 6'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd8, 5'd11,
                  32'h5, 32'h6, 32'h9, 6'd0);
    #1;
    expectSig("rt_reg_stall", S_STALL, 32'd1);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 5'd8, 5'd0,
                  32'd0, 32'd0, 32'd0, 6'd0);
    #1;
    expectSig("inv_stall", S_STALL, 32'd0);
    checkOutput();

    // A load to $0 never stalls.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0,
                  32'd0, 32'd0, 32'd0, 6'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd12,
                  32'd0, 32'd0, 32'd0, 6'd0);
    #1;
    expectSig("r0ld_stall", S_STALL, 32'd0);
    checkOutput();

    // Flush wins over a pending load-use stall.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd8,
                  32'd0, 32'd0, 32'd0, 6'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 5'd3, 5'd13,
                  32'h33, 32'h44, 32'd0, 6'h05);
    flush = 1'b1;
    #1;
    expectSig("fl_stall", S_STALL, 32'd0);
    checkOutput();
    tick();
    flush = 1'b0;
    #1;
    expectSig("fl_valid", S_VALID, 32'd0);
    expectSig("fl_rw", S_RW, 32'd0);
    expectSig("fl_stall_after", S_STALL, 32'd0);
    checkOutput();
    tick();
    expectSig("fl_next_valid", S_VALID, 32'd1);
    expectSig("fl_next_wr", S_WR, 32'd13);
    checkOutput();

    for (int i = 0; i < 5 && sbQ.size() > 0; i++) @(negedge clk);
    if (sbQ.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending want 0", sbQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
